// File: rtl/msrh_dcache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// msrh_dcache_refill_ctrl
//   Miss/refill sequencer for the L1 data cache array. Miss requests from the
//   LSU ports and the store port are held per port, arbitrated round-robin,
//   fetched one line at a time from L2 and written into the tag/data array.
//   Every port waiting on the refilled line is released together (merge).
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_miss_valid/paddr        per-port miss request (port k at k*PADDR_W)
//   o_miss_ready              port k has no miss outstanding
//   o_l2_req_*                line fetch request to L2 (valid/ready)
//   i_l2_resp_*               single-beat refill data from L2
//   o_dc_update_*             array write port (valid/addr/data/byte enables)
//   o_refill_done/addr        one-cycle refill-complete pulse with line addr
//   o_busy                    FSM active or any miss pending
// ---------------------------------------------------------------------------
module msrh_dcache_refill_ctrl #(
    parameter int REQ_NUM = 3,
    parameter int PADDR_W = 56,
    parameter int LINE_W  = 128
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [REQ_NUM-1:0]           i_miss_valid,
    input  logic [REQ_NUM*PADDR_W-1:0]   i_miss_paddr,
    output logic [REQ_NUM-1:0]           o_miss_ready,
    output logic                         o_l2_req_valid,
    input  logic                         i_l2_req_ready,
    output logic [PADDR_W-1:0]           o_l2_req_addr,
    input  logic                         i_l2_resp_valid,
    input  logic [LINE_W-1:0]            i_l2_resp_data,
    output logic                         o_dc_update_valid,
    output logic [PADDR_W-1:0]           o_dc_update_addr,
    output logic [LINE_W-1:0]            o_dc_update_data,
    output logic [LINE_W/8-1:0]          o_dc_update_be,
    output logic                         o_refill_done,
    output logic [PADDR_W-1:0]           o_refill_addr,
    output logic                         o_busy
);

    localparam int LINE_OFF = $clog2(LINE_W/8);
    localparam int PTR_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam logic [PADDR_W-1:0] LINE_MASK = ~(PADDR_W'((1 << LINE_OFF) - 1));

    typedef enum logic [2:0] {
        IDLE,
        L2_REQ,
        WAIT_RESP,
        WRITE,
        DONE
    } state_t;

    state_t               r_state;
    logic [REQ_NUM-1:0]   r_pend;
    logic [PADDR_W-1:0]   r_line [REQ_NUM];
    logic [PADDR_W-1:0]   r_cur;
    logic [LINE_W-1:0]    r_data;
    logic [PTR_W-1:0]     r_ptr;

    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     ptr_nxt;

    // First pending port at or after r_ptr, wrapping at REQ_NUM.
    always_comb begin : grant_sel
        logic [31:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            idx = 32'(r_ptr) + i;
            if (idx >= 32'(REQ_NUM)) begin
                idx = idx - 32'(REQ_NUM);
            end
            if (!grant_vld && r_pend[idx]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        ptr_nxt = (32'(grant_idx) == 32'(REQ_NUM - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_line  <= '{default: '0};
            r_cur   <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
        end else begin
            // Merge-clear in DONE first; a same-cycle accept overrides it.
            for (int unsigned k = 0; k < REQ_NUM; k++) begin
                if (r_state == DONE && r_pend[k] && r_line[k] == r_cur) begin
                    r_pend[k] <= 1'b0;
                end
                if (i_miss_valid[k] && !r_pend[k]) begin
                    r_pend[k] <= 1'b1;
                    r_line[k] <= i_miss_paddr[k*PADDR_W +: PADDR_W] & LINE_MASK;
                end
            end

            case (r_state)
                IDLE: begin
                    if (grant_vld) begin
                        r_cur   <= r_line[grant_idx];
                        r_ptr   <= ptr_nxt;
                        r_state <= L2_REQ;
                    end
                end
                L2_REQ: begin
                    if (i_l2_req_ready) begin
                        r_state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (i_l2_resp_valid) begin
                        r_data  <= i_l2_resp_data;
                        r_state <= WRITE;
                    end
                end
                WRITE:   r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_miss_ready      = ~r_pend;
    assign o_l2_req_valid    = (r_state == L2_REQ);
    assign o_l2_req_addr     = (r_state == L2_REQ) ? r_cur : '0;
    assign o_dc_update_valid = (r_state == WRITE);
    assign o_dc_update_addr  = (r_state == WRITE) ? r_cur : '0;
    assign o_dc_update_data  = (r_state == WRITE) ? r_data : '0;
    assign o_dc_update_be    = (r_state == WRITE) ? '1 : '0;
    assign o_refill_done     = (r_state == DONE);
    assign o_refill_addr     = (r_state == DONE) ? r_cur : '0;
    assign o_busy            = (r_state != IDLE) || (|r_pend);

endmodule
